// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte image, packs it into little-endian
// 32-bit words for instruction memory, then acks with one tx byte and raises done.
module prog_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           loaded_len,
   output logic [2:0]            state_dbg
);

   // Handshakes: a byte moves on rx_valid && rx_ready; the ack byte moves on
   // tx_valid && tx_ready. A valid never drops or changes before its transfer.
   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_ACK, S_DONE, S_ERR
   } state_t;

   localparam logic [32:0] CAPACITY = 33'(4) << ADDR_WIDTH;

   state_t      state, state_nx;
   logic [1:0]  lane;
   logic [31:0] byte_cnt;
   logic [31:0] buf_q;
   logic [31:0] word_nx;
   logic        rx_fire;
   logic        load_go;
   logic        last_byte;

   assign state_dbg = state;
   assign rx_fire   = rx_valid && rx_ready;
   assign load_go   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   assign last_byte = (byte_cnt == loaded_len - 32'd1);

   // Buffer with the incoming byte merged into its lane; in LEN this is the length field.
   always_comb begin
      word_nx = buf_q;
      word_nx[8*lane +: 8] = rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = 1'b0;
      done     = 1'b0;
      error    = 1'b0;
      case (state)
         S_IDLE: if (start) state_nx = S_LEN;
         S_LEN: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid && lane == 2'd3) begin
               if (word_nx == 32'd0)                  state_nx = S_ACK;
               else if ({1'b0, word_nx} > CAPACITY)   state_nx = S_ERR;
               else                                   state_nx = S_DATA;
            end
         end
         S_DATA: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
            if (rx_valid && last_byte) state_nx = S_ACK;
         end
         S_ACK: begin
            tx_valid = 1'b1;
            tx_data  = ACK_BYTE;
            busy     = 1'b1;
            if (tx_ready) state_nx = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) state_nx = S_LEN;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) state_nx = S_LEN;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane       <= 2'd0;
         byte_cnt   <= 32'd0;
         buf_q      <= 32'd0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'd0;
         loaded_len <= 32'd0;
      end else begin
         mem_we <= 1'b0;
         if (load_go) begin
            lane     <= 2'd0;
            byte_cnt <= 32'd0;
            buf_q    <= 32'd0;
         end else if (rx_fire) begin
            lane <= lane + 2'd1;
            if (state == S_LEN) begin
               if (lane == 2'd3) begin
                  loaded_len <= word_nx;
                  buf_q      <= 32'd0;
               end else begin
                  buf_q <= word_nx;
               end
            end else begin
               byte_cnt <= byte_cnt + 32'd1;
               // Commit on a full word or on the final byte; unfilled lanes stay zero.
               if (lane == 2'd3 || last_byte) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= byte_cnt[ADDR_WIDTH+1:2];
                  mem_wdata <= word_nx;
                  buf_q     <= 32'd0;
               end else begin
                  buf_q <= word_nx;
               end
            end
         end
      end
   end

endmodule
